// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: glyph ROM, blank pattern,
// digit-count limit and a width helper.
package seg_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for nibbles 0..F.
    localparam logic [6:0] GLYPHS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Host-side value bus and board-side pin bundle of seg_scan_driver.
// Blink mask member exists only when SEG_SCAN_BLINK_EN is defined.
interface seg_scan_driver_if #(
    parameter int DIGITS = 4
);
    // load_i is a single-cycle strobe with no ready: the driver always accepts it,
    // and pending_o stays high until the shadow has been committed at a frame start.
    logic [4*DIGITS-1:0] value_i;
    logic [DIGITS-1:0]   dp_i;
    logic                load_i;
    logic                lz_blank_i;
`ifdef SEG_SCAN_BLINK_EN
    logic [DIGITS-1:0]   blink_mask_i;
`endif
    logic [6:0]          seg_o;
    logic                dp_o;
    logic [DIGITS-1:0]   an_o;
    logic                frame_o;
    logic                pending_o;

    modport master (
        output value_i, dp_i, load_i, lz_blank_i,
`ifdef SEG_SCAN_BLINK_EN
        output blink_mask_i,
`endif
        input  seg_o, dp_o, an_o, frame_o, pending_o
    );

    modport slave (
        input  value_i, dp_i, load_i, lz_blank_i,
`ifdef SEG_SCAN_BLINK_EN
        input  blink_mask_i,
`endif
        output seg_o, dp_o, an_o, frame_o, pending_o
    );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational nibble to active-low seven-segment glyph.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = GLYPHS[i_nib];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with frame-synchronous commit.
// Optional blinking of masked digits is enabled by defining SEG_SCAN_BLINK_EN.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
`ifdef SEG_SCAN_BLINK_EN
   ,parameter int BLINK_FRAMES = 32
`endif
) (
    input logic              clk,
    input logic              rst_n,
    seg_scan_driver_if.slave bus
);

    localparam int PW = idx_width(SCAN_DIV);
    localparam int IW = idx_width(DIGITS);
    localparam logic [PW-1:0] P_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] P_SHOW   = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]       r_p;
    logic [IW-1:0]       r_idx;
    logic [4*DIGITS-1:0] r_shadow_val, r_active_val;
    logic [DIGITS-1:0]   r_shadow_dp, r_active_dp;
    logic                r_pending;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_an;
    logic                r_frame;

    logic                w_wrap, w_frame_edge, w_show;
    logic                w_zero_run, w_lz_hit, w_dp_sel, w_mask_sel, w_mask_off;
    logic [3:0]          w_nib;
    logic [6:0]          w_glyph, w_seg_nxt;
    logic                w_dp_nxt;
    logic [DIGITS-1:0]   w_an_nxt;

    assign w_wrap       = (r_p == P_LAST);
    assign w_frame_edge = w_wrap && (r_idx == IDX_LAST);
    assign w_show       = (r_p >= P_SHOW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p   <= '0;
            r_idx <= '0;
        end else if (w_wrap) begin
            r_p   <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_p <= r_p + 1'b1;
        end
    end

    // Commit reads the pre-load shadow; a same-cycle load re-arms pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_active_val <= '0;
            r_active_dp  <= '0;
            r_pending    <= 1'b0;
        end else begin
            if (w_frame_edge && r_pending) begin
                r_active_val <= r_shadow_val;
                r_active_dp  <= r_shadow_dp;
                r_pending    <= 1'b0;
            end
            if (bus.load_i) begin
                r_shadow_val <= bus.value_i;
                r_shadow_dp  <= bus.dp_i;
                r_pending    <= 1'b1;
            end
        end
    end

    // Walk from the top digit down so w_zero_run covers nibbles idx..DIGITS-1.
    always_comb begin
        w_nib      = '0;
        w_dp_sel   = 1'b0;
        w_mask_sel = 1'b0;
        w_lz_hit   = 1'b0;
        w_zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_zero_run = w_zero_run && (r_active_val[4*k +: 4] == 4'h0);
            if (IW'(k) == r_idx) begin
                w_nib    = r_active_val[4*k +: 4];
                w_dp_sel = r_active_dp[k];
                w_lz_hit = w_zero_run && (k != 0);
`ifdef SEG_SCAN_BLINK_EN
                w_mask_sel = bus.blink_mask_i[k];
`endif
            end
        end
    end

    seg_hex_decode u_dec (
        .i_nib (w_nib),
        .o_seg (w_glyph)
    );

`ifdef SEG_SCAN_BLINK_EN
    localparam int FW = idx_width(BLINK_FRAMES);
    localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] r_frame_cnt;
    logic          r_blink_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (w_frame_edge) begin
            if (r_frame_cnt == F_LAST) begin
                r_frame_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign w_mask_off = w_mask_sel && !r_blink_on;
`else
    assign w_mask_off = w_mask_sel;
`endif

    always_comb begin
        w_an_nxt  = '1;
        w_seg_nxt = SEG_OFF;
        w_dp_nxt  = 1'b1;
        if (w_show) begin
            w_an_nxt  = ~(DIGITS'(1) << r_idx);
            w_seg_nxt = ((bus.lz_blank_i && w_lz_hit) || w_mask_off) ? SEG_OFF : w_glyph;
            w_dp_nxt  = w_mask_off | ~w_dp_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg   <= SEG_OFF;
            r_dp    <= 1'b1;
            r_an    <= '1;
            r_frame <= 1'b0;
        end else begin
            r_seg   <= w_seg_nxt;
            r_dp    <= w_dp_nxt;
            r_an    <= w_an_nxt;
            r_frame <= w_frame_edge;
        end
    end

    assign bus.seg_o     = r_seg;
    assign bus.dp_o      = r_dp;
    assign bus.an_o      = r_an;
    assign bus.frame_o   = r_frame;
    assign bus.pending_o = r_pending;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: directed scenarios plus random loads,
// checked every cycle against a time-indexed display model.
module tb_seg_scan_driver;
    import seg_pkg::*;

    localparam int D     = 4;
    localparam int S     = 8;
    localparam int B     = 2;
    localparam int BF    = 2;
    localparam int FRAME = D * S;
    localparam int VW    = 4 * D;
    localparam int W     = D + 9;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    seg_scan_driver_if #(.DIGITS(D)) bus ();

    seg_scan_driver #(
        .DIGITS       (D),
        .SCAN_DIV     (S),
        .BLANK_CYCLES (B)
`ifdef SEG_SCAN_BLINK_EN
       ,.BLINK_FRAMES (BF)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: t = clock edges since reset release; display buffers as plain values.
    int              t;
    logic [VW-1:0]   m_sh_val, m_act_val;
    logic [D-1:0]    m_sh_dp, m_act_dp;
    logic            m_pend;
    logic [W-1:0]    exp_q[$];
`ifdef SEG_SCAN_BLINK_EN
    logic [D-1:0]    tb_mask;
    assign bus.blink_mask_i = tb_mask;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        string      on;
        logic [6:0] g;
        g = 7'h7F;
        case (n)
            4'h0: on = "abcdef";
            4'h1: on = "bc";
            4'h2: on = "abdeg";
            4'h3: on = "abcdg";
            4'h4: on = "bcfg";
            4'h5: on = "acdfg";
            4'h6: on = "acdefg";
            4'h7: on = "abc";
            4'h8: on = "abcdefg";
            4'h9: on = "abcdfg";
            4'hA: on = "abcefg";
            4'hB: on = "cdefg";
            4'hC: on = "adef";
            4'hD: on = "bcdeg";
            4'hE: on = "adefg";
            default: on = "aefg";
        endcase
        for (int i = 0; i < on.len(); i++) g[int'(on[i]) - 97] = 1'b0;
        return g;
    endfunction

    // Pins seen during the cycle after time t: {an, seg, dp, frame}.
    function automatic logic [W-1:0] expect_out();
        int         pos, dig;
        logic [D-1:0] an;
        logic [6:0] seg;
        logic       dpx, fr, off;
        pos = t % S;
        dig = (t / S) % D;
        an  = '1;
        seg = 7'h7F;
        dpx = 1'b1;
        off = 1'b0;
        fr  = ((t % FRAME) == FRAME - 1);
`ifdef SEG_SCAN_BLINK_EN
        off = tb_mask[dig] && ((((t / FRAME) / BF) % 2) == 1);
`endif
        if (pos >= B) begin
            an[dig] = 1'b0;
            if (off || (bus.lz_blank_i && dig != 0 && (m_act_val >> (4 * dig)) == '0))
                seg = 7'h7F;
            else
                seg = glyph(m_act_val[4*dig +: 4]);
            dpx = off | ~m_act_dp[dig];
        end
        return {an, seg, dpx, fr};
    endfunction

    task automatic model_reset();
        t         = 0;
        m_sh_val  = '0;
        m_act_val = '0;
        m_sh_dp   = '0;
        m_act_dp  = '0;
        m_pend    = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_an"},    32'(bus.an_o),      32'({D{1'b1}}));
        check({tag, "_seg"},   32'(bus.seg_o),     32'h7F);
        check({tag, "_dp"},    32'(bus.dp_o),      32'h1);
        check({tag, "_frame"}, 32'(bus.frame_o),   32'h0);
        check({tag, "_pend"},  32'(bus.pending_o), 32'h0);
    endtask

    task automatic step();
        logic [W-1:0]  e;
        logic          ld;
        logic [VW-1:0] v;
        logic [D-1:0]  d;
        exp_q.push_back(expect_out());
        ld = bus.load_i;
        v  = bus.value_i;
        d  = bus.dp_i;
        @(posedge clk);
        if ((t % FRAME) == FRAME - 1 && m_pend) begin
            m_act_val = m_sh_val;
            m_act_dp  = m_sh_dp;
            m_pend    = 1'b0;
        end
        if (ld) begin
            m_sh_val = v;
            m_sh_dp  = d;
            m_pend   = 1'b1;
        end
        t++;
        #1;
        e = exp_q.pop_front();
        check("an_o",      32'(bus.an_o),      32'(e[W-1 -: D]));
        check("seg_o",     32'(bus.seg_o),     32'(e[8:2]));
        check("dp_o",      32'(bus.dp_o),      32'(e[1]));
        check("frame_o",   32'(bus.frame_o),   32'(e[0]));
        check("pending_o", 32'(bus.pending_o), 32'(m_pend));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input logic [VW-1:0] v, input logic [D-1:0] d);
        bus.value_i = v;
        bus.dp_i    = d;
        bus.load_i  = 1'b1;
        step();
        bus.load_i  = 1'b0;
    endtask

    task automatic run_to(input int phase);
        for (int i = 0; i < FRAME && (t % FRAME) != phase; i++) step();
    endtask

    initial begin
        bus.value_i    = '0;
        bus.dp_i       = '0;
        bus.load_i     = 1'b0;
        bus.lz_blank_i = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
        tb_mask = 4'b0001;
`endif
        model_reset();

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;

        // Idle scan of zeros, frame pulses every FRAME cycles.
        run(2 * FRAME);

        // Load mid-frame; commit at next frame start.
        run(5);
        load(16'h12AF, 4'b0100);
        run(2 * FRAME + 8);

        // Leading-zero blanking.
        bus.lz_blank_i = 1'b1;
        load(16'h0005, 4'b0000);
        run(2 * FRAME);
        load(16'h0000, 4'b0010);
        run(2 * FRAME);
        bus.lz_blank_i = 1'b0;

        // Load colliding with the commit cycle.
        run_to(3);
        load(16'h1111, 4'b0000);
        run_to(FRAME - 1);
        load(16'h9999, 4'b1000);
        run(2 * FRAME + 4);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bus.load_i  = ($urandom_range(0, 15) == 0);
            bus.value_i = ($urandom_range(0, 1) == 0) ? VW'($urandom_range(0, 255)) : VW'($urandom);
            bus.dp_i    = D'($urandom);
            if ($urandom_range(0, 31) == 0) bus.lz_blank_i = ~bus.lz_blank_i;
            step();
        end
        bus.load_i = 1'b0;

        // Asynchronous reset in the digit-2 slot.
        load(16'h4321, 4'b0000);
        run_to(2 * S + 5);
        check("pre_rst_an", 32'(bus.an_o), 32'(4'b1011));
        #3 rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        check_reset("held_rst");
        @(negedge clk);
        rst_n = 1'b1;
        run(FRAME + 4);
        load(16'hC0DE, 4'b0101);
        run(2 * FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
